motion_sequencer: RTL

- Semi-automatic driving sequencer. It accepts one-shot manoeuvre commands (step forward, turn left 90°, turn right 90°, turn around 180°).
- Each command is expanded into timed, mutually exclusive motion pulses: turn, then forward, then settle. These pulses drive the car motion outputs.
- Sits between the semi-auto decision logic (command source) and the car motion/output stage. Only one manoeuvre is active at a time.

---
 rtl/motion_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/motion_sequencer.sv
// Manoeuvre sequencer: expands one-shot drive commands into timed, mutually
// exclusive turn -> forward -> settle motion pulses for the car output stage.
module motion_sequencer #(
    parameter int TURN90_CYCLES  = 90000000,
    parameter int FORWARD_CYCLES = 50000000,
    parameter int SETTLE_CYCLES  = 10000000,
    parameter int CNT_W          = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    output logic       busy,
    output logic       done,
    output logic       turn_left_signal,
    output logic       turn_right_signal,
    output logic       move_forward_signal,
    output logic       move_backward_signal
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TURN,
        ST_FORWARD,
        ST_SETTLE
    } state_t;

    localparam logic [1:0] CMD_STEP   = 2'b00;
    localparam logic [1:0] CMD_LEFT   = 2'b01;
    localparam logic [1:0] CMD_AROUND = 2'b11;

    localparam logic [CNT_W-1:0] TURN90_LOAD  = CNT_W'(TURN90_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN180_LOAD = CNT_W'(2 * TURN90_CYCLES - 1);
    localparam logic [CNT_W-1:0] FORWARD_LOAD = CNT_W'(FORWARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_cmd;
    logic             r_busy;
    logic             r_done;
    logic             r_turn_left;
    logic             r_turn_right;
    logic             r_move_forward;
    logic             w_accept;
    logic             w_cnt_zero;

    assign cmd_ready  = enable && (r_state == ST_IDLE);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_cnt_zero = (r_cnt == '0);

    // NOTE: all state lives in this one clocked block and uses non-blocking
    // assignments, so every output reflects the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_cmd          <= 2'b00;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_turn_left    <= 1'b0;
            r_turn_right   <= 1'b0;
            r_move_forward <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!enable && (r_state != ST_IDLE)) begin
                // Abort: drop every drive at once and skip the done pulse.
                r_state        <= ST_IDLE;
                r_cnt          <= '0;
                r_busy         <= 1'b0;
                r_turn_left    <= 1'b0;
                r_turn_right   <= 1'b0;
                r_move_forward <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_cmd  <= cmd;
                            r_busy <= 1'b1;
                            if (cmd == CMD_STEP) begin
                                r_state        <= ST_FORWARD;
                                r_cnt          <= FORWARD_LOAD;
                                r_move_forward <= 1'b1;
                            end else begin
                                r_state      <= ST_TURN;
                                r_cnt        <= (cmd == CMD_AROUND) ? TURN180_LOAD : TURN90_LOAD;
                                r_turn_left  <= (cmd == CMD_LEFT);
                                r_turn_right <= (cmd != CMD_LEFT);
                            end
                        end
                    end
                    ST_TURN: begin
                        if (w_cnt_zero) begin
                            r_state        <= ST_FORWARD;
                            r_cnt          <= FORWARD_LOAD;
                            r_turn_left    <= 1'b0;
                            r_turn_right   <= 1'b0;
                            r_move_forward <= 1'b1;
                        end else begin
                            r_cnt        <= r_cnt - 1'b1;
                            r_turn_left  <= (r_cmd == CMD_LEFT);
                            r_turn_right <= (r_cmd != CMD_LEFT);
                        end
                    end
                    ST_FORWARD: begin
                        if (w_cnt_zero) begin
                            r_state        <= ST_SETTLE;
                            r_cnt          <= SETTLE_LOAD;
                            r_move_forward <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (w_cnt_zero) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy                 = r_busy;
    assign done                 = r_done;
    assign turn_left_signal     = r_turn_left;
    assign turn_right_signal    = r_turn_right;
    assign move_forward_signal  = r_move_forward;
    assign move_backward_signal = 1'b0;

endmodule
